// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : FSM state encoding and WIDTH legal-range constants for serial_adder.
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int C_WIDTH_MIN = 2;
    localparam int C_WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
// Module   : fa_cell
// Purpose  : 1-bit combinational full adder shared by every bit of the operation.
// Revision : 1.0 - initial release
// ============================================================================
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial add/subtract, one result bit per clock LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    generate
        if (WIDTH < C_WIDTH_MIN || WIDTH > C_WIDTH_MAX) begin : g_bad_width
            $error("serial_adder: WIDTH out of legal range");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_s;
    logic               r_c;
    logic               r_co;
    logic               r_ovf;
    logic               w_accept;
    logic               w_last;
    logic               w_fa_s;
    logic               w_fa_co;

    assign w_accept = (r_state != ST_RUN) && start;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    fa_cell u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_c),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Subtraction is folded in at latch time: B is stored inverted and the
    // borrow-in becomes an inverted carry-in, so the run phase is mode-agnostic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_s   <= '0;
            r_c   <= 1'b0;
            r_co  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_a   <= a;
            r_b   <= sub ? ~b : b;
            r_c   <= ci ^ sub;
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_s   <= {w_fa_s, r_s[WIDTH-1:1]};
            r_c   <= w_fa_co;
            if (w_last) begin
                r_co  <= w_fa_co;
                r_ovf <= r_c ^ w_fa_co;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign s    = r_s;
    assign co   = r_co;
    assign ovf  = r_ovf;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed and reference-model checks of serial_adder at WIDTH 2/8/64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sub, ci, busy, done, co, ovf;
    logic [7:0]  a, b, s;
    logic        start2, sub2, ci2, busy2, done2, co2, ovf2;
    logic [1:0]  a2, b2, s2;
    logic        start64, sub64, ci64, busy64, done64, co64, ovf64;
    logic [63:0] a64, b64, s64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2), .ci(ci2),
        .busy(busy2), .done(done2), .s(s2), .co(co2), .ovf(ovf2)
    );

    serial_adder #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .sub(sub64), .a(a64), .b(b64), .ci(ci64),
        .busy(busy64), .done(done64), .s(s64), .co(co64), .ovf(ovf64)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: {co, ovf, s} for a w-bit operation, s zero-extended to 64 bits.
    function automatic logic [65:0] model(input int w, input logic [63:0] ta, input logic [63:0] tb,
                                          input logic tci, input logic tsub);
        logic [64:0] mask, bb, full;
        logic [63:0] ss;
        logic        cc, ov;
        mask = (65'd1 << w) - 65'd1;
        bb   = {1'b0, tb} ^ (tsub ? mask : 65'd0);
        full = {1'b0, ta} + bb + 65'(tci ^ tsub);
        cc   = full[w];
        ss   = full[63:0] & mask[63:0];
        ov   = (ta[w-1] == bb[w-1]) && (ss[w-1] != ta[w-1]);
        return {cc, ov, ss};
    endfunction

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tci, input logic tsub,
                       input logic rel, output int lat, output int bcnt);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        start = 1'b1; a = ta; b = tb; ci = tci; sub = tsub;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic op2(input logic [1:0] ta, input logic [1:0] tb, input logic tci, input logic tsub);
        int lat;
        @(negedge clk);
        start2 = 1'b1; a2 = ta; b2 = tb; ci2 = tci; sub2 = tsub;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w2_latency", 128'(lat), 128'(2));
        check("w2_result", 128'({co2, ovf2, 62'd0, s2}), 128'(model(2, 64'(ta), 64'(tb), tci, tsub)));
    endtask

    task automatic op64(input logic [63:0] ta, input logic [63:0] tb, input logic tci, input logic tsub);
        int lat;
        @(negedge clk);
        start64 = 1'b1; a64 = ta; b64 = tb; ci64 = tci; sub64 = tsub;
        @(posedge clk); #1;
        start64 = 1'b0;
        lat = 0;
        while (!done64 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w64_latency", 128'(lat), 128'(64));
        check("w64_result", 128'({co64, ovf64, s64}), 128'(model(64, ta, tb, tci, tsub)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, bcnt, ndone;
        logic [9:0] cap;

        rst_n = 1'b0;
        start = 0; sub = 0; ci = 0; a = 0; b = 0;
        start2 = 0; sub2 = 0; ci2 = 0; a2 = 0; b2 = 0;
        start64 = 0; sub64 = 0; ci64 = 0; a64 = 0; b64 = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_w8", 128'({busy, done, co, ovf, s}), 128'(0));
        check("reset_w64", 128'({busy64, done64, co64, ovf64, s64}), 128'(0));

        // First start is driven together with reset release.
        op8(8'h5A, 8'h33, 1'b0, 1'b0, 1'b1, lat, bcnt);
        check("add_5a_33_latency", 128'(lat), 128'(8));
        check("add_5a_33_busy_cycles", 128'(bcnt), 128'(8));
        check("add_5a_33", 128'({co, ovf, s}), 128'({1'b0, 1'b1, 8'h8D}));
        @(posedge clk); #1;
        check("done_one_cycle", 128'(done), 128'(0));
        check("hold_after_done", 128'({co, ovf, s}), 128'({1'b0, 1'b1, 8'h8D}));

        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, lat, bcnt);
        check("add_ff_01", 128'({co, ovf, s}), 128'({1'b1, 1'b0, 8'h00}));
        op8(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, lat, bcnt);
        check("add_7f_00_ci", 128'({co, ovf, s}), 128'({1'b0, 1'b1, 8'h80}));
        op8(8'h10, 8'h20, 1'b0, 1'b1, 1'b0, lat, bcnt);
        check("sub_10_20", 128'({co, ovf, s}), 128'({1'b0, 1'b0, 8'hF0}));
        op8(8'h20, 8'h10, 1'b1, 1'b1, 1'b0, lat, bcnt);
        check("sub_20_10_bi", 128'({co, ovf, s}), 128'({1'b1, 1'b0, 8'h0F}));

        // Issued while the previous operation is in DONE.
        op8(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, lat, bcnt);
        check("b2b_latency", 128'(lat), 128'(8));
        check("b2b_busy_cycles", 128'(bcnt), 128'(8));
        check("b2b_result", 128'({co, ovf, s}), 128'({1'b0, 1'b0, 8'h02}));
        @(posedge clk); #1;

        // start held through RUN with operands changed after acceptance.
        @(negedge clk);
        start = 1'b1; a = 8'h5A; b = 8'h33; ci = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 8'hAA; b = 8'h55; ci = 1'b1; sub = 1'b1;
        ndone = 0; cap = '0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            if (i == 7) start = 1'b0;
            if (done) begin
                ndone++;
                cap = {co, ovf, s};
            end
        end
        check("held_start_done_count", 128'(ndone), 128'(1));
        check("held_start_result", 128'(cap), 128'({1'b0, 1'b1, 8'h8D}));

        // Reset asserted in the third RUN cycle.
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; ci = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", 128'({busy, done, co, ovf, s}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrun_reset_no_done", 128'(ndone), 128'(0));
        op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, lat, bcnt);
        check("after_reset_result", 128'({co, ovf, s}), 128'({1'b0, 1'b0, 8'h46}));

        for (int ia = 0; ia < 4; ia++)
            for (int ib = 0; ib < 4; ib++)
                for (int m = 0; m < 4; m++)
                    op2(2'(ia), 2'(ib), m[0], m[1]);

        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        op64(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            op64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 sub  input  1  mode: 0 = add, 1 = subtract; latched with start.
REQ-006 a  input  WIDTH  operand A; latched with start.
REQ-007 b  input  WIDTH  operand B; latched with start.
REQ-008 ci  input  1  carry-in (add) or borrow-in (subtract); latched with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when s/co/ovf become valid.
REQ-011 s  output  WIDTH  sum/difference.
REQ-012 co  output  1  carry-out; in subtract mode 1 = no borrow.
REQ-013 ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-014 The block SHALL compute one result bit per clock, LSB first, through a single 1-bit full-adder cell.
REQ-015 Add mode SHALL produce {co,s} = a + b + ci.
REQ-016 Subtract mode SHALL produce {co,s} = a + ~b + ~ci, i.e. a - b - ci with co = NOT borrow.
REQ-017 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 IDLE or DONE with start=1 SHALL latch a, b, ci and sub, clear the bit counter and go to RUN.
REQ-020 DONE with start=0 SHALL go to IDLE.
REQ-021 RUN SHALL process bit[cnt] each edge; the edge on which cnt = WIDTH-1 SHALL go to DONE.
REQ-022 busy SHALL be 1 exactly in RUN, i.e. for WIDTH cycles.
REQ-023 done SHALL be 1 exactly in DONE, asserted WIDTH edges after the edge that accepted start.
REQ-024 start during RUN SHALL be ignored; changes on a, b, ci or sub after acceptance SHALL NOT affect the result.
REQ-025 s, co and ovf SHALL hold their last valid value from DONE until the next accepted start.
REQ-026 During RUN, s, co and ovf SHALL be treated as invalid; a bench SHALL NOT check them there.
REQ-027 start in the DONE cycle SHALL be accepted, giving back-to-back operations with no IDLE gap.

Reset
REQ-028 rst_n=0 SHALL, asynchronously and at any point including mid-RUN, force state IDLE, busy=0, done=0, s=0, co=0, ovf=0, counter=0 and internal operand registers to 0.
REQ-029 An operation interrupted by reset SHALL be discarded and SHALL produce no done pulse.
REQ-030 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package serial_adder_pkg SHALL hold the FSM state typedef/encoding and the WIDTH legal-range constants.
REQ-032 The 1-bit combinational full adder SHALL be a sub-module named fa_cell (ports s, co, a, b, ci), instantiated once.
REQ-033 The bit counter width SHALL be $clog2(WIDTH); operand and result storage SHALL be shift registers.

Verification (WIDTH=8)
REQ-034 a=0x5A b=0x33 ci=0 sub=0 -> s=0x8D co=0 ovf=1; done exactly 8 edges after start; busy high for 8 cycles.
REQ-035 a=0xFF b=0x01 ci=0 sub=0 -> s=0x00 co=1 ovf=0; a=0x7F b=0x00 ci=1 -> s=0x80 co=0 ovf=1.
REQ-036 a=0x10 b=0x20 ci=0 sub=1 -> s=0xF0 co=0 ovf=0; a=0x20 b=0x10 ci=1 sub=1 -> s=0x0F co=1 ovf=0.
REQ-037 start held high throughout RUN with operands changed to 0xAA/0x55 -> result of the first operation unchanged; exactly one done pulse.
REQ-038 rst_n pulsed low on the 3rd RUN cycle -> all outputs 0 immediately, no done pulse; a fresh operation afterwards gives the correct result.
REQ-039 start asserted in the DONE cycle with a=0x01 b=0x01 -> busy=1 on the next cycle; s=0x02 after 8 more edges; exhaustive random check against a + b reference model for WIDTH=2, 8 and 64.
